// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//
// Streams one 8x8x8 light-cube frame (512 bits, frame_cube_flat layout) out of
// a UART as a single packet: HEADER, 64 data bytes (byte 0 first), then an
// 8-bit additive checksum of the data bytes. Every byte goes out 8N1, LSB
// first, with no idle gap between bytes inside a packet.
//
// Parameters
//   BAUD_DIV        clock cycles per UART bit (2..65535)
//   HEADER          first byte of every packet
//
// Ports
//   clk             system clock
//   resetn          asynchronous active-low reset
//   en              enables acceptance of new frames
//   frame_cube_flat frame to send; byte i = frame_cube_flat[8*i+7:8*i]
//   frame_valid     a frame is offered
//   frame_ready     en && idle; a frame is accepted when valid && ready
//   tx              UART line, idle high (registered)
//   busy            high while a packet is in progress (registered)
//   done            one-cycle pulse after the last stop bit (registered)
// -----------------------------------------------------------------------------
module uart_frame_tx #(
  parameter int unsigned BAUD_DIV = 868,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic [511:0] frame_cube_flat,
  input  logic         frame_valid,
  output logic         frame_ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [6:0]  LAST_IDX  = 7'd65;  // checksum byte
  localparam logic [6:0]  CSUM_PREV = 7'd64;  // last data byte

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  baud_q, baud_d;
  logic [2:0]   bit_q, bit_d;
  logic [6:0]   idx_q, idx_d;
  logic [7:0]   csum_q, csum_d;
  logic [7:0]   byte_q, byte_d;    // byte being shifted out, bit 0 on the line
  logic [511:0] frame_q, frame_d;  // remaining data bytes, next byte in [7:0]
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  assign frame_ready = en && (state_q == IDLE);
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx is registered, so the line value for the next bit period is decided on
  // the same edge that moves the FSM into that period.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (frame_valid && frame_ready) begin
          state_d = START;
          frame_d = frame_cube_flat;
          byte_d  = HEADER;
          baud_d  = '0;
          bit_d   = '0;
          idx_d   = '0;
          csum_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = byte_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d  = bit_q + 3'd1;
            byte_d = {1'b0, byte_q[7:1]};
            tx_d   = byte_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 7'd1;
            bit_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
            if (idx_q == CSUM_PREV) begin
              // All 64 data bytes have been summed by now.
              byte_d = csum_q;
            end else begin
              byte_d  = frame_q[7:0];
              frame_d = {8'h00, frame_q[511:8]};
              csum_d  = csum_q + frame_q[7:0];
            end
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Serialises one 8×8×8 light-cube frame (512 bits, the same `frame_cube_flat` layout the display path uses) into a framed UART packet on `tx`. It is the transmit counterpart of the cube's UART frame receiver. It sits beside `frame_buffer` so a board can stream its current frame to a host or to a second cube. Each packet is: header byte, 64 data bytes, then an 8-bit additive checksum, all sent 8N1, LSB first.

## Interface
- `BAUD_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2..65535.
- `HEADER`, default 8'hA5: first byte of every packet.
- `clk` in 1: system clock, 100 MHz.
- `resetn` in 1: one clock; reset is asynchronous and active-low.
- `en` in 1: enables acceptance of new frames.
- `frame_cube_flat` in 512: frame to send. Byte i is `frame_cube_flat[8*i+7:8*i]`, for i = 0..63.
- `frame_valid` in 1: a frame is offered.
- `frame_ready` out 1: the block can accept a frame. Defined as `en && state==IDLE`.
- `tx` out 1: UART line, idle high. Registered.
- `busy` out 1: high while a packet is in progress. Registered.
- `done` out 1: one-cycle pulse at the end of a packet. Registered.

## Operation
- Handshake: a frame is accepted on a rising edge where `frame_valid && frame_ready`.
  - The whole 512-bit frame is latched into a shift buffer on that edge.
  - Later changes on `frame_cube_flat` do not affect the packet.
- Packet sequence uses byte index 0..65:
  - index 0 = `HEADER`
  - index 1..64 = data bytes 0..63
  - index 65 = checksum
- Checksum is the sum of the 64 data bytes, mod 256. The 8-bit accumulator wraps and excludes the header. It is built while bytes are loaded for sending.
- Bit FSM states and transitions:
  - IDLE: `tx`=1. Goes to START on accept.
  - START: `tx`=0 for BAUD_DIV cycles, then goes to DATA.
  - DATA: bits 0..7 of the current byte, LSB first, BAUD_DIV cycles each, then goes to STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles. If byte index < 65, increment the index and go to START. Otherwise go to IDLE.
- There is no idle gap between bytes inside a packet.
- Counters:
  - Baud counter counts 0..BAUD_DIV-1, 16 bits.
  - Bit counter counts 0..7.
  - Byte index counts 0..65, 7 bits.
  - All counters clear on entering START from IDLE.
- If `en` deasserts mid-packet, the packet completes. No new frame is accepted afterwards until `en` returns.
- `frame_valid` while busy is ignored (`frame_ready`=0). The frame is not queued.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, state=IDLE, all counters 0, checksum 0.
- `frame_ready` equals `en` out of reset.
- Asserting reset mid-packet forces `tx`=1 and `busy`=0 asynchronously. The packet is abandoned with no `done`.
- Latency: on accept edge T, `tx`=0 and `busy`=1 from cycle T+1.
- Every bit is held for exactly BAUD_DIV cycles.
- Packet length is 66 × 10 × BAUD_DIV cycles: `tx` is low from T+1 and the last stop bit ends at cycle T+660·BAUD_DIV.
- On the cycle after the last stop-bit cycle:
  - `done`=1 for exactly one cycle.
  - `busy`=0.
  - `frame_ready`=`en`.
- Back-to-back: if `frame_valid` is held, the next accept happens on the `done` cycle. The next start bit begins the following cycle, so there is exactly one idle-high cycle between packets.

## Test plan
- Reset with BAUD_DIV=4, all-zero frame, one accept:
  - UART monitor decodes A5, 64×00, then 00.
  - `busy` high for 2640 cycles.
  - `done` pulses once.
- Frame with byte i = i:
  - Decodes A5, 00..3F, then checksum E0.
- All-0xFF frame:
  - Checksum C0 (wraps from 0x3FC0).
  - Every data bit period is exactly 4 cycles high, checked by a bit-width checker.
- During transmission:
  - Change `frame_cube_flat` and pulse `frame_valid` → packet content unchanged, no second packet.
  - Drop `en` at byte 30 → packet completes, `frame_ready` stays 0 afterwards.
- Hold `frame_valid`=1 with `en`=1 → two consecutive packets separated by exactly one idle-high cycle, `done` pulsing once per packet.
- Assert `resetn`=0 during data byte 10:
  - `tx`=1 before the next clock edge.
  - No `done`.
  - After release, a new frame transmits correctly from the header.
